// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Two-requester scheduler in front of the ALU operand-gating stage. The
//   execute stage (requester 0) and the address-calc unit (requester 1)
//   compete for a single ALU slot. The winner's operands are latched, the
//   gating enable is held for LAT settle cycles, the ALU result is captured
//   and returned through a valid/ready response port. Only one operation is
//   in flight at any time.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_reqN_valid/o_reqN_ready  request handshake for requester N (0/1)
//   i_reqN_a/_b/_fn         requester N operands and function code
//   o_alu_en                operand-gating enable (high LAT cycles per op)
//   o_alu_a/_b/_fn          latched operands / function to the ALU
//   i_alu_result            ALU output, sampled on the last enabled cycle
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_id, o_rsp_data    owning requester and captured result
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; ready asserted toward the winner
// ST_ISSUE | operands driven, alu_en high, counting LAT settle cycles
// ST_RESP  | result held on rsp_data until the consumer takes it

module alu_issue_arbiter #(
  parameter int WIDTH = 64,
  parameter int LAT   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,

  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [1:0]       i_req0_fn,

  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [1:0]       i_req1_fn,

  output logic             o_alu_en,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_fn,
  input  logic [WIDTH-1:0] i_alu_result,

  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Counter value on the final enabled cycle; LAT is limited to 1..15.
  localparam logic [3:0] LP_CNT_LAST = 4'(LAT - 1);

  state_t           r_state;
  state_t           w_next_state;

  logic             r_prio;
  logic [3:0]       r_cnt;
  logic             r_id;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_fn;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_cnt_last;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [1:0]       w_sel_fn;

  // A lone requester always wins; on contention the prio holder wins.
  // prio flips to the other requester after each completed response,
  // which makes grants alternate under sustained contention.
  assign w_grant0 = i_req0_valid && (!i_req1_valid || (r_prio == 1'b0));
  assign w_grant1 = i_req1_valid && (!i_req0_valid || (r_prio == 1'b1));

  assign w_accept   = (r_state == ST_IDLE) && (w_grant0 || w_grant1);
  assign w_cnt_last = (r_state == ST_ISSUE) && (r_cnt == LP_CNT_LAST);
  assign w_rsp_fire = (r_state == ST_RESP) && i_rsp_ready;

  assign w_sel_a  = w_grant1 ? i_req1_a  : i_req0_a;
  assign w_sel_b  = w_grant1 ? i_req1_b  : i_req0_b;
  assign w_sel_fn = w_grant1 ? i_req1_fn : i_req0_fn;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept)    w_next_state = ST_ISSUE;
      ST_ISSUE: if (w_cnt_last)  w_next_state = ST_RESP;
      ST_RESP:  if (i_rsp_ready) w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // Ready is combinational from the grant; it is also forced low while
  // reset is asserted so every output reads zero during reset, even if a
  // requester keeps valid high.
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_alu_en     = 1'b0;
    if (!i_rst) begin
      o_req0_ready = (r_state == ST_IDLE) && w_grant0;
      o_req1_ready = (r_state == ST_IDLE) && w_grant1;
      o_alu_en     = (r_state == ST_ISSUE);
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_fn    = r_alu_fn;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

  // ---------------------------------------------------------------------
  // Issue datapath: settle counter, operand latches, winner index
  // ---------------------------------------------------------------------
  // Operands are registered at accept and zeroed when ISSUE ends, so the
  // gating stage sees zeros outside ISSUE without extra output muxing.
  // The function code is left as-is since it does not toggle datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_id     <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_fn <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_id     <= w_grant1;
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_alu_fn <= w_sel_fn;
      end else if (r_state == ST_ISSUE) begin
        if (w_cnt_last) begin
          r_cnt   <= '0;
          r_alu_a <= '0;
          r_alu_b <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Response datapath and fairness pointer
  // ---------------------------------------------------------------------
  // rsp_data/rsp_id keep their last value after the handshake; only
  // rsp_valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_prio      <= 1'b0;
    end else begin
      if (w_cnt_last) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_data  <= i_alu_result;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
        r_prio      <= ~r_rsp_id;
      end
    end
  end

endmodule
